ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
- Synthesizable AHB slave that sits directly downstream of the bus interface and responds to the master-side transfers carried on it.
- Provides a single-port word-organised SRAM with a configurable number of wait states.
- Returns a two-cycle ERROR response for illegal accesses.
- Serves as the DUT endpoint for the UVM master agent, and as the reference behaviour for the slave agent's scoreboard.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 16..4096.
- WAIT_STATES, 0: HREADY-low cycles inserted before each OKAY completion; range 0..15.

Ports:
- HCLK  input  1  bus clock; all logic is rising-edge.
- HRESET  input  1  asynchronous, active-high reset.
- HTRANS  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HBURST  input  3  burst type; not used for decode.
- HSIZE  input  3  transfer size: 0=byte, 1=half, 2=word.
- HADDR  input  32  byte address (address phase).
- HWRITE  input  1  1=write, 0=read (address phase).
- HWDATA  input  32  write data (data phase).
- HREADY  output  1  transfer done / slave ready; this is the only slave, so it also qualifies the address phase.
- HRESP  output  2  OKAY=00, ERROR=01; RETRY and SPLIT are never driven.
- HRDATA  output  32  read data; registered.

Behaviour:
- Reset (async assert, sync release): HREADY=1, HRESP=00, HRDATA=0, FSM=ST_OK, wait counter=0, address-phase register cleared. Memory contents are not reset.
- Address phase is accepted on a rising edge where HREADY==1 and HTRANS is NONSEQ or SEQ. IDLE/BUSY are never accepted and give OKAY with zero wait.
- Legality check at acceptance. A transfer is legal when:
  - BASE_ADDR <= HADDR < BASE_ADDR + 4*DEPTH_WORDS;
  - HSIZE <= 2;
  - it is aligned: half needs HADDR[0]==0, word needs HADDR[1:0]==0.
- Any illegal transfer goes to the error path. The memory is not touched.
- Captured on acceptance: word index (HADDR-BASE_ADDR)>>2, byte lanes, HWRITE, legal flag.
- Lane rules (little-endian):
  - byte: lane HADDR[1:0];
  - half: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
- FSM states; outputs are registered and encode the current data-phase cycle:
  - ST_OK: HREADY=1, HRESP=00.
  - ST_WAIT: HREADY=0, HRESP=00; the counter decrements each cycle. ST_WAIT -> ST_OK when the counter reaches 0.
  - ST_ERR1: HREADY=0, HRESP=01. ST_ERR1 -> ST_ERR2 unconditionally.
  - ST_ERR2: HREADY=1, HRESP=01.
- Transitions out of ST_OK/ST_ERR2 (HREADY==1):
  - legal accept, WAIT_STATES>0 -> ST_WAIT, counter=WAIT_STATES-1;
  - legal accept, WAIT_STATES==0 -> ST_OK;
  - illegal accept -> ST_ERR1 (no wait states precede an error);
  - no accept -> ST_OK.
- Write commit: on the rising edge that ends the data phase (HREADY==1 in that cycle), HWDATA is written to the captured lanes. Unselected lanes are preserved.
- Read: HRDATA is loaded on the edge that enters the final (HREADY=1) data-phase cycle, with the full 32-bit word at the captured index. It holds until the next read load. It is not loaded for writes or errors.
- Read-after-write bypass: if a read's load edge coincides with a write commit to the same word, HRDATA returns the merged post-write value.
- Pipelining: back-to-back transfers with no IDLE are supported. Zero wait gives one completion per cycle.
- HBURST is ignored. The 1 KB boundary is not checked. The master is responsible for cancelling a burst after ERROR.
- Reset mid-transfer: the pending write is dropped, and outputs return to reset values immediately.

Decomposition:
- Shared package ahb_pkg (shared with the UVM env):
  - enums htrans_e, hresp_e, hsize_e, hburst_e;
  - localparams for OKAY/ERROR codes.
- Sub-module ahb_sram_array: DEPTH_WORDS x 32 storage with 4-bit byte-enable synchronous write and asynchronous read port. The bypass merge lives in the parent.

Test Plan:
- WAIT_STATES=0: NONSEQ write word 0xDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back -> write completes in 1 cycle OKAY; read HRDATA=0xDEADBEEF next cycle (bypass path).
- WAIT_STATES=2: read @0x20 -> HREADY 0,0,1 across data phase; HRESP=00 throughout; HRDATA valid in the third cycle.
- Byte/half lanes: word 0x11223344 @0x40; byte write 0xAA @0x41; half write 0xBBCC @0x42 -> word read returns 0xBBCCAA44.
- Errors: read @BASE+4*DEPTH_WORDS (0x400), then half write @0x01 -> each gives HRESP=01 with HREADY 0 then 1. Word @0x00 is unchanged afterwards.
- IDLE/BUSY: HTRANS=IDLE and BUSY with HADDR=0xFFFF_FFFF -> HREADY=1, HRESP=00, no error, memory untouched.
- Reset mid-wait: WAIT_STATES=3, assert HRESET during the second wait cycle of a write 0x5555_5555 @0x80 -> HREADY=1, HRESP=00, HRDATA=0 immediately; a later read @0x80 returns the pre-write value.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the SRAM slave and its verification environment,
// plus the slave's data-phase states and the little-endian byte-lane helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Each state is one data-phase cycle; HREADY/HRESP decode directly from it.
    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } sram_state_e;

    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << addr_lo;
            3'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised storage: byte-enabled synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ahb_sram_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable OKAY wait states and a two-cycle ERROR
// response for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    sram_state_e   state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;

    logic          dp_valid_q, dp_write_q, dp_legal_q;
    logic [AW-1:0] dp_idx_q;
    logic [3:0]    dp_be_q;

    logic [32:0]   addr_off;
    logic          accept, aligned, legal;
    logic [AW-1:0] ap_idx;
    logic [3:0]    ap_be;

    logic          wr_commit, rd_fast, rd_slow;
    logic [AW-1:0] rd_idx;
    logic [31:0]   mem_rdata, rd_word, hrdata_q;
    logic          unused_hburst;

    assign unused_hburst = ^HBURST;

    // 33-bit subtraction: a borrow into bit 32 puts HADDR below the window.
    assign addr_off = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign accept   = HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign ap_idx   = addr_off[AW+1:2];
    assign ap_be    = byte_lanes(HSIZE, HADDR[1:0]);

    always_comb begin
        aligned = 1'b1;
        case (HSIZE)
            3'd1:    aligned = ~HADDR[0];
            3'd2:    aligned = (HADDR[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign legal = (addr_off < SPAN) && (HSIZE <= 3'd2) && aligned;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_OK;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_WAIT: begin
                if (wcnt_q == 4'd0) state_d = ST_OK;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (!accept) begin
                    state_d = ST_OK;
                end else if (!legal) begin
                    state_d = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    wcnt_d  = WAIT_LOAD;
                end else begin
                    state_d = ST_OK;
                end
            end
        endcase
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        case (state_q)
            ST_WAIT: HREADY = 1'b0;
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = RESP_ERROR;
            end
            ST_ERR2: HRESP = RESP_ERROR;
            default: ;
        endcase
    end

    // Address-phase capture; held while the current data phase is stalled.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_legal_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_be_q    <= 4'd0;
        end else if (HREADY) begin
            dp_valid_q <= accept;
            if (accept) begin
                dp_write_q <= HWRITE;
                dp_legal_q <= legal;
                dp_idx_q   <= ap_idx;
                dp_be_q    <= ap_be;
            end
        end
    end

    assign wr_commit = HREADY && dp_valid_q && dp_write_q && dp_legal_q;
    // Zero-wait reads load on the accept edge; waited reads on the WAIT->OK edge.
    assign rd_fast   = (WAIT_STATES == 0) && accept && legal && !HWRITE;
    assign rd_slow   = (state_q == ST_WAIT) && (wcnt_q == 4'd0) && dp_valid_q && !dp_write_q;
    assign rd_idx    = rd_fast ? ap_idx : dp_idx_q;

    ahb_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (HCLK),
        .we    (wr_commit),
        .be    (dp_be_q),
        .waddr (dp_idx_q),
        .wdata (HWDATA),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    always_comb begin
        rd_word = mem_rdata;
        if (wr_commit && (dp_idx_q == rd_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)                hrdata_q <= 32'h0;
        else if (rd_fast || rd_slow) hrdata_q <= rd_word;
    end

    assign HRDATA = hrdata_q;

endmodule
